// File: rtl/anton_neopixel_sequencer_pkg.sv
// Shared types, defaults and helpers for the NeoPixel frame sequencer.
package anton_neopixel_sequencer_pkg;

    // Sequencer state. The values match the 1-bit state encoding that the stream stage decodes.
    typedef enum logic {
        STATE_RESET    = 1'b0,
        STATE_TRANSMIT = 1'b1
    } seqState_t;

    // Default last byte index of the pixel buffer.
    localparam int unsigned BUFFER_END_DEFAULT   = 255;
    // Default latch (low) time between frames, in pattern-clock cycles.
    localparam int unsigned RESET_CYCLES_DEFAULT = 420;

    // Each colour bit is eight pattern slots, and each pixel is 24 colour bits.
    localparam logic [2:0] PATTERN_LAST = 3'd7;
    localparam logic [4:0] BIT_LAST     = 5'd23;

    // Limits the requested last pixel so the frame never addresses past the buffer.
    // A 32-bit pixel occupies four bytes, so fewer whole pixels fit in that mode.
    function automatic int unsigned clampLastPixel(
        input int unsigned regMaxVal,
        input int unsigned bufferEnd,
        input logic        is32
    );
        int unsigned limit;
        limit = is32 ? (((bufferEnd + 1) / 4) - 1) : bufferEnd;
        return (regMaxVal > limit) ? limit : regMaxVal;
    endfunction

endpackage

// File: rtl/anton_neopixel_sequencer.sv
// Registered timing generator for the NeoPixel stream stage: it walks pattern slots,
// colour bits and pixels for one frame, then holds the latch period before the next frame.
module anton_neopixel_sequencer
    import anton_neopixel_sequencer_pkg::*;
#(
    parameter  int unsigned BUFFER_END   = BUFFER_END_DEFAULT,
    parameter  int unsigned RESET_CYCLES = RESET_CYCLES_DEFAULT,
    localparam int unsigned BUFFER_BITS  = $clog2(BUFFER_END + 1)
) (
    input  logic                   clk7mhz,
    input  logic                   resetn,
    input  logic                   regCtrlRun,
    input  logic                   regCtrlLoop,
    input  logic                   regCtrl32bit,
    input  logic [BUFFER_BITS-1:0] regMax,
    output logic                   state,
    output logic [BUFFER_BITS-1:0] pixelIndex,
    output logic [4:0]             pixelBitIndex,
    output logic [2:0]             bitPatternIndex,
    output logic                   streamEnd,
    output logic                   runClear
);

    localparam int unsigned            RESET_BITS = $clog2(RESET_CYCLES);
    localparam logic [RESET_BITS-1:0]  RESET_LAST = RESET_BITS'(RESET_CYCLES - 1);

    seqState_t                stateQ, stateD;
    logic [RESET_BITS-1:0]    resetCnt, resetCntD;
    logic [BUFFER_BITS-1:0]   pixelCnt, pixelCntD;
    logic [BUFFER_BITS-1:0]   lastPixel, lastPixelD;
    logic                     mode32, mode32D;
    logic [4:0]               pixelBitD;
    logic [2:0]               patternD;
    logic [BUFFER_BITS-1:0]   pixelIndexD;
    logic [BUFFER_BITS+1:0]   pixelByteD;
    logic                     streamEndD, runClearD;

    assign state = stateQ;

    // Next-state logic for the state register, counter chain, frame latches and pulses.
    always_comb begin
        stateD     = stateQ;
        resetCntD  = resetCnt;
        pixelCntD  = pixelCnt;
        lastPixelD = lastPixel;
        mode32D    = mode32;
        pixelBitD  = pixelBitIndex;
        patternD   = bitPatternIndex;
        streamEndD = 1'b0;
        runClearD  = 1'b0;

        case (stateQ)
            STATE_RESET: begin
                if (resetCnt != RESET_LAST) begin
                    resetCntD = resetCnt + 1'b1;
                end else if (regCtrlRun) begin
                    stateD     = STATE_TRANSMIT;
                    pixelCntD  = '0;
                    pixelBitD  = '0;
                    patternD   = '0;
                    mode32D    = regCtrl32bit;
                    lastPixelD = BUFFER_BITS'(clampLastPixel(32'(regMax), BUFFER_END, regCtrl32bit));
                end
            end

            STATE_TRANSMIT: begin
                if (!regCtrlRun) begin
                    // Abort: restart the full latch period and park all indices.
                    stateD    = STATE_RESET;
                    resetCntD = '0;
                    pixelCntD = '0;
                    pixelBitD = '0;
                    patternD  = '0;
                end else if (bitPatternIndex != PATTERN_LAST) begin
                    patternD = bitPatternIndex + 3'd1;
                end else begin
                    patternD = '0;
                    if (pixelBitIndex != BIT_LAST) begin
                        pixelBitD = pixelBitIndex + 5'd1;
                    end else begin
                        pixelBitD = '0;
                        if (pixelCnt == lastPixel) begin
                            stateD     = STATE_RESET;
                            resetCntD  = '0;
                            pixelCntD  = '0;
                            streamEndD = 1'b1;
                            runClearD  = !regCtrlLoop;
                        end else begin
                            pixelCntD = pixelCnt + 1'b1;
                        end
                    end
                end
            end

            default: begin
                stateD    = STATE_RESET;
                resetCntD = '0;
                pixelCntD = '0;
                pixelBitD = '0;
                patternD  = '0;
            end
        endcase

        // pixelIndex is derived from the next-cycle count and format so it can be a flop
        // and still line up with the other indices.
        pixelByteD  = {pixelCntD, 2'b00};
        pixelIndexD = mode32D ? pixelByteD[BUFFER_BITS-1:0] : pixelCntD;
    end

    // State register, counters, frame latches and registered outputs.
    always_ff @(posedge clk7mhz or negedge resetn) begin
        if (!resetn) begin
            stateQ          <= STATE_RESET;
            resetCnt        <= '0;
            pixelCnt        <= '0;
            lastPixel       <= '0;
            mode32          <= 1'b0;
            pixelBitIndex   <= '0;
            bitPatternIndex <= '0;
            pixelIndex      <= '0;
            streamEnd       <= 1'b0;
            runClear        <= 1'b0;
        end else begin
            stateQ          <= stateD;
            resetCnt        <= resetCntD;
            pixelCnt        <= pixelCntD;
            lastPixel       <= lastPixelD;
            mode32          <= mode32D;
            pixelBitIndex   <= pixelBitD;
            bitPatternIndex <= patternD;
            pixelIndex      <= pixelIndexD;
            streamEnd       <= streamEndD;
            runClear        <= runClearD;
        end
    end

endmodule

// File: tb/tb_anton_neopixel_sequencer.sv
// Scoreboard bench for the NeoPixel sequencer: a frame-offset reference model predicts
// every cycle's outputs, and a negedge monitor compares them against the DUT.
module tb_anton_neopixel_sequencer;

    localparam int unsigned BE = 15;
    localparam int unsigned RC = 8;
    localparam int unsigned BB = $clog2(BE + 1);
    localparam int          CYCLES_PER_PIXEL = 192;

    logic          clk = 1'b0;
    logic          resetn;
    logic          run;
    logic          loopMode;
    logic          m32;
    logic [BB-1:0] regMax;

    logic          st;
    logic [BB-1:0] pixelIndex;
    logic [4:0]    pixelBitIndex;
    logic [2:0]    bitPatternIndex;
    logic          streamEnd;
    logic          runClear;

    int assertCount = 0;
    int failCount   = 0;
    int cycleNo     = 0;

    typedef struct {
        int st;
        int pix;
        int pbit;
        int pat;
        int se;
        int rc;
    } exp_t;

    exp_t expQ[$];

    always #5 clk = ~clk;

    anton_neopixel_sequencer #(
        .BUFFER_END   (BE),
        .RESET_CYCLES (RC)
    ) dut (
        .clk7mhz         (clk),
        .resetn          (resetn),
        .regCtrlRun      (run),
        .regCtrlLoop     (loopMode),
        .regCtrl32bit    (m32),
        .regMax          (regMax),
        .state           (st),
        .pixelIndex      (pixelIndex),
        .pixelBitIndex   (pixelBitIndex),
        .bitPatternIndex (bitPatternIndex),
        .streamEnd       (streamEnd),
        .runClear        (runClear)
    );

    // Reference model: a frame is a span of offsets k = 0..(last+1)*192-1, and every output
    // is plain arithmetic on k; between frames the model counts low clock edges.
    initial begin : refModel
        bit   inTx;
        int   k;
        int   lastPix;
        bit   mode;
        int   lowEdges;
        int   lim;
        int   px;
        exp_t e;
        inTx = 0; k = 0; lastPix = 0; mode = 0; lowEdges = 0;
        forever begin
            @(posedge clk or negedge resetn);
            e = '{0, 0, 0, 0, 0, 0};
            if (!resetn) begin
                inTx = 0;
                lowEdges = 0;
                expQ.delete();
                expQ.push_back(e);
            end else begin
                if (!inTx) begin
                    lowEdges++;
                    if (lowEdges >= RC && run) begin
                        lim     = m32 ? ((BE + 1) / 4 - 1) : BE;
                        lastPix = (int'(regMax) > lim) ? lim : int'(regMax);
                        mode    = m32;
                        k       = 0;
                        inTx    = 1;
                    end
                end else if (!run) begin
                    inTx = 0;
                    lowEdges = 0;
                end else if (k == (lastPix + 1) * CYCLES_PER_PIXEL - 1) begin
                    inTx = 0;
                    lowEdges = 0;
                    e.se = 1;
                    e.rc = loopMode ? 0 : 1;
                end else begin
                    k++;
                end
                if (inTx) begin
                    px     = k / CYCLES_PER_PIXEL;
                    e.st   = 1;
                    e.pix  = (mode ? px * 4 : px) % (1 << BB);
                    e.pbit = (k / 8) % 24;
                    e.pat  = k % 8;
                end
                expQ.push_back(e);
            end
        end
    end

    // Monitor: pops one expectation per cycle and compares it with the DUT outputs.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            cycleNo++;
            assertCount++;
            if (expQ.size() == 0) begin
                failCount++;
                $display("FAIL scoreboard_empty cycle %0d: no expectation queued", cycleNo);
            end else begin
                e = expQ.pop_front();
                if (int'(st) != e.st || int'(pixelIndex) != e.pix || int'(pixelBitIndex) != e.pbit ||
                    int'(bitPatternIndex) != e.pat || int'(streamEnd) != e.se || int'(runClear) != e.rc) begin
                    failCount++;
                    $display("FAIL outputs cycle %0d: got st=%0d pix=%0d bit=%0d pat=%0d end=%0d clr=%0d, want st=%0d pix=%0d bit=%0d pat=%0d end=%0d clr=%0d",
                             cycleNo, st, pixelIndex, pixelBitIndex, bitPatternIndex, streamEnd, runClear,
                             e.st, e.pix, e.pbit, e.pat, e.se, e.rc);
                end
            end
        end
    end

    task automatic checkEq(input string name, input int act, input int req);
        assertCount++;
        if (act != req) begin
            failCount++;
            $display("FAIL %s: got %0d, want %0d", name, act, req);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
        #2;
    endtask

    // Waits for the register-block clear request, then drops Run as the register block would.
    task automatic waitRunClear(input string name, input int budget);
        bit seen;
        seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (runClear) seen = 1;
        end
        #2;
        if (!seen) checkEq({name, "_runClear_timeout"}, 0, 1);
        run = 1'b0;
    endtask

    initial begin : stimulus
        bit found;
        int w;
        resetn = 1'b0; run = 1'b1; loopMode = 1'b0; m32 = 1'b0; regMax = BB'(2);
        cycles(3);

        // 8-bit single frame, three pixels.
        resetn = 1'b1;
        waitRunClear("single8", 1000);
        cycles(20);

        // 32-bit frames: two pixels, then an over-range request clamped to four.
        m32 = 1'b1; regMax = BB'(1); run = 1'b1;
        waitRunClear("mode32_two", 1000);
        cycles(10);
        regMax = BB'(9); run = 1'b1;
        waitRunClear("mode32_clamp", 1500);
        cycles(10);

        // Loop mode: back-to-back one-pixel frames.
        m32 = 1'b0; regMax = BB'(0); loopMode = 1'b1; run = 1'b1;
        cycles(RC + 200 * 3 + 10);
        run = 1'b0;
        cycles(12);
        loopMode = 1'b0;

        // Mid-frame abort at pixel 1, bit 5, pattern 3, with an early re-assert of Run.
        regMax = BB'(3); run = 1'b1;
        found = 0;
        for (int i = 0; i < 1500 && !found; i++) begin
            @(negedge clk);
            if (st && pixelIndex == BB'(1) && pixelBitIndex == 5'd5 && bitPatternIndex == 3'd3) found = 1;
        end
        #2;
        checkEq("abort_point_reached", int'(found), 1);
        run = 1'b0;
        cycles(2);
        run = 1'b1;
        waitRunClear("after_abort", 1500);
        cycles(10);

        // Asynchronous reset in the middle of a frame.
        regMax = BB'(2); run = 1'b1;
        cycles(300);
        @(posedge clk);
        #2;
        checkEq("async_pre_state", int'(st), 1);
        resetn = 1'b0;
        #1;
        checkEq("async_state", int'(st), 0);
        checkEq("async_pixelIndex", int'(pixelIndex), 0);
        checkEq("async_pixelBitIndex", int'(pixelBitIndex), 0);
        checkEq("async_bitPatternIndex", int'(bitPatternIndex), 0);
        checkEq("async_streamEnd", int'(streamEnd), 0);
        checkEq("async_runClear", int'(runClear), 0);
        @(negedge clk);
        #2;
        resetn = 1'b1;
        waitRunClear("after_async", 1000);
        cycles(10);

        // Clamp in 8-bit mode with mid-frame changes to the frame parameters.
        regMax = BB'(20 % (1 << BB)) | BB'(BE); run = 1'b1;
        cycles(500);
        regMax = BB'(1); m32 = 1'b1;
        cycles(700);
        regMax = BB'(0); m32 = 1'b0;
        waitRunClear("clamp8", 3500);
        cycles(10);

        // Randomized frames with mid-frame perturbations and occasional aborts.
        for (int f = 0; f < 6; f++) begin
            regMax = BB'($urandom_range(0, 6));
            m32    = 1'($urandom_range(0, 1));
            run    = 1'b1;
            w      = int'($urandom_range(50, 400));
            cycles(w);
            regMax = BB'($urandom_range(0, BE));
            m32    = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) begin
                run = 1'b0;
                cycles(3);
            end else begin
                waitRunClear("random_frame", 2500);
                cycles(5);
            end
        end

        cycles(15);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
